// File: rtl/alu_exec_stage.sv
// Sequential ALU execute stage: latches op/A/B on a valid/ready accept, computes plain ops in
// one cycle and shifts one bit per cycle, then holds C/zero/carry until writeback takes them.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             carry
);

  localparam int unsigned EW = WIDTH + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] c_q;
  logic             zero_q;
  logic             carry_q;
  logic [SHW-1:0]   cnt_q;
  logic             shl_q;

  logic             accept_c;
  logic             is_shift_c;
  logic [SHW-1:0]   shamt_c;
  logic [EW-1:0]    sum_c;
  logic [EW-1:0]    diff_c;
  logic [WIDTH-1:0] res_c;
  logic             cy_c;
  logic [WIDTH-1:0] shift_nxt_c;
  logic             shift_out_c;

  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid  = (state_q == DONE);
  assign C          = c_q;
  assign zero       = zero_q;
  assign carry      = carry_q;

  assign accept_c   = in_valid && in_ready;
  assign is_shift_c = (op == OP_SHL) || (op == OP_SHR);
  assign shamt_c    = B[SHW-1:0];

  // Single-cycle result; a shift by zero passes A through with no carry.
  always_comb begin
    sum_c  = {1'b0, A} + {1'b0, B};
    diff_c = {1'b0, A} - {1'b0, B};
    res_c  = '0;
    cy_c   = 1'b0;
    case (op)
      OP_ADD: begin res_c = sum_c[WIDTH-1:0];  cy_c = sum_c[WIDTH];  end
      OP_SUB: begin res_c = diff_c[WIDTH-1:0]; cy_c = diff_c[WIDTH]; end
      OP_AND: res_c = A & B;
      OP_OR:  res_c = A | B;
      OP_XOR: res_c = A ^ B;
      OP_NOT: res_c = ~A;
      OP_SHL: res_c = A;
      OP_SHR: res_c = A;
      default: res_c = '0;
    endcase
  end

  // One-bit step of the working register (C doubles as the shift register).
  always_comb begin
    shift_nxt_c = '0;
    shift_out_c = 1'b0;
    if (shl_q) begin
      shift_nxt_c = {c_q[WIDTH-2:0], 1'b0};
      shift_out_c = c_q[WIDTH-1];
    end else begin
      shift_nxt_c = {1'b0, c_q[WIDTH-1:1]};
      shift_out_c = c_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
    end else if (state_q == SHIFT) begin
      c_q     <= shift_nxt_c;
      carry_q <= shift_out_c;
      cnt_q   <= cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) begin
        state_q <= DONE;
        zero_q  <= (shift_nxt_c == '0);
      end
    end else if (accept_c) begin
      if (is_shift_c && (shamt_c != '0)) begin
        state_q <= SHIFT;
        c_q     <= A;
        zero_q  <= 1'b0;
        carry_q <= 1'b0;
        cnt_q   <= shamt_c;
        shl_q   <= (op == OP_SHL);
      end else begin
        state_q <= DONE;
        c_q     <= res_c;
        zero_q  <= (res_c == '0);
        carry_q <= cy_c;
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_q <= IDLE;
    end
  end

endmodule
